uart_console_tx: RTL and testbench



---
 rtl/uart_console_tx_if.sv | 11 +
 rtl/uart_console_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_console_tx.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_console_tx_if.sv
// Control half of the phoeniX data-memory bus as seen by the console transmitter.
// The shared data bus stays a plain inout port on the device.
interface uart_console_tx_if;
   logic        enable;
   logic        state;
   logic [31:0] address;
   logic [3:0]  frame_mask;

   modport master (output enable, state, address, frame_mask);
   modport slave  (input  enable, state, address, frame_mask);
endinterface

// File: rtl/uart_console_tx.sv
// Memory-mapped console transmitter: byte stores are queued in a FIFO and sent as
// 8N1 UART frames; STATUS and BAUD registers share the same 16-byte window.
module uart_console_tx #(
   parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic               clk,
   input  logic               reset,
   uart_console_tx_if.slave   bus,
   inout  wire  [31:0]        data_memory_interface_data,
   output logic               uart_tx,
   output logic               tx_busy
);

   localparam int unsigned AW          = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic        BUS_READ    = 1'b0;
   localparam logic        BUS_WRITE   = 1'b1;

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  START = 2'd1;
   localparam logic [1:0]  DATA  = 2'd2;
   localparam logic [1:0]  STOP  = 2'd3;

   localparam logic [1:0]  REG_TXDATA = 2'd0;
   localparam logic [1:0]  REG_STATUS = 2'd1;
   localparam logic [1:0]  REG_BAUD   = 2'd2;
   localparam logic [1:0]  REG_NONE   = 2'd3;

   logic          hit;
   logic          rd_hit;
   logic          wr_hit;
   logic [1:0]    sel;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic          rd_drive;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overflow;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          ovf_clear;

   logic [15:0]   baud;
   logic [15:0]   eff_div;

   logic [1:0]    ser_state;
   logic [7:0]    shift;
   logic [15:0]   div_lat;
   logic [15:0]   cyc_cnt;
   logic [2:0]    bit_idx;
   logic          bit_done;
   logic          ser_ready;

   logic          unused_bits;

   // Bus decode
   assign hit     = bus.enable && (bus.address[31:4] == BASE_ADDRESS[31:4]);
   assign sel     = bus.address[3:2];
   assign rd_hit  = hit && (bus.state == BUS_READ);
   assign wr_hit  = hit && (bus.state == BUS_WRITE);
   assign wr_data = data_memory_interface_data;

   assign push_req  = wr_hit && (sel == REG_TXDATA) && bus.frame_mask[3];
   assign ovf_clear = wr_hit && (sel == REG_STATUS) && bus.frame_mask[3] && wr_data[3];

   assign fifo_full  = (count == FULL_COUNT);
   assign fifo_empty = (count == '0);

   // The serializer only sees the registered count, so a fresh push waits one edge.
   assign bit_done  = (cyc_cnt == div_lat - 16'd1);
   assign ser_ready = (ser_state == IDLE) || ((ser_state == STOP) && bit_done);
   assign pop       = ser_ready && !fifo_empty;
   assign push_ok   = push_req && (!fifo_full || pop);

   assign eff_div = (baud == '0) ? 16'd1 : baud;
   assign tx_busy = (ser_state != IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= wr_data[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push_ok) begin
            count <= count - 1'b1;
         end
         if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
         end else if (ovf_clear) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud <= 16'(CLKS_PER_BIT);
      end else if (wr_hit && (sel == REG_BAUD)) begin
         if (bus.frame_mask[3]) begin
            baud[7:0] <= wr_data[7:0];
         end
         if (bus.frame_mask[2]) begin
            baud[15:8] <= wr_data[15:8];
         end
      end
   end

   // Serializer: the divisor is latched per frame so BAUD writes apply from the next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ser_state <= IDLE;
         shift     <= '0;
         div_lat   <= 16'd1;
         cyc_cnt   <= '0;
         bit_idx   <= '0;
         uart_tx   <= 1'b1;
      end else begin
         case (ser_state)
            IDLE: begin
               if (pop) begin
                  shift     <= fifo_mem[rd_ptr];
                  div_lat   <= eff_div;
                  cyc_cnt   <= '0;
                  uart_tx   <= 1'b0;
                  ser_state <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  uart_tx   <= shift[0];
                  shift     <= {1'b0, shift[7:1]};
                  bit_idx   <= '0;
                  cyc_cnt   <= '0;
                  ser_state <= DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     uart_tx   <= 1'b1;
                     ser_state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  if (pop) begin
                     shift     <= fifo_mem[rd_ptr];
                     div_lat   <= eff_div;
                     uart_tx   <= 1'b0;
                     ser_state <= START;
                  end else begin
                     ser_state <= IDLE;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 16'd1;
               end
            end
            default: begin
               ser_state <= IDLE;
               uart_tx   <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         REG_STATUS: begin
            rd_data[0]          = tx_busy;
            rd_data[1]          = fifo_full;
            rd_data[2]          = fifo_empty;
            rd_data[3]          = overflow;
            rd_data[8 +: AW+1]  = count;
         end
         REG_BAUD: rd_data[15:0] = baud;
         default:  rd_data       = '0;
      endcase
   end

   assign rd_drive = rd_hit && (sel != REG_NONE);
   assign data_memory_interface_data = rd_drive ? rd_data : 'z;

   assign unused_bits = ^{bus.address[1:0], bus.frame_mask[1:0], wr_data[31:16]};

endmodule

// File: tb/tb_uart_console_tx.sv
// Scoreboard bench for uart_console_tx: a queue-level model predicts frames, register
// reads and tx_busy; independent monitors decode uart_tx and the bus and compare.
`timescale 1ns/1ps
module tb_uart_console_tx;
   localparam logic [31:0] BASE      = 32'h1000_0000;
   localparam int unsigned DEPTH     = 16;
   localparam logic        BUS_READ  = 1'b0;
   localparam logic        BUS_WRITE = 1'b1;

   typedef struct {
      logic [7:0]  b;
      int unsigned d;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_tx;
   logic        tx_busy;
   logic        drive_en = 1'b0;
   logic [31:0] wdata = '0;
   logic        rd_active = 1'b0;
   wire  [31:0] bus_data;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [7:0]  mq[$];
   frame_t      exp_q[$];
   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];
   longint      start_q[$];
   logic [15:0] m_baud = 16'd16;
   bit          m_ovf = 1'b0;
   bit          ser_busy = 1'b0;
   longint      ser_end = 0;
   longint      m_cycle = 0;

   always #5 clk = ~clk;

   uart_console_tx_if bus_if ();

   assign bus_data = drive_en ? wdata : 'z;
   pullup (bus_data);

   uart_console_tx #(
      .BASE_ADDRESS (BASE),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (16)
   ) dut (
      .clk                        (clk),
      .reset                      (rst_n),
      .bus                        (bus_if),
      .data_memory_interface_data (bus_data),
      .uart_tx                    (uart_tx),
      .tx_busy                    (tx_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: a byte queue plus the edge at which the current frame ends.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         m_baud   = 16'd16;
         m_ovf    = 1'b0;
         ser_busy = 1'b0;
         ser_end  = 0;
      end else begin : step
         int unsigned pre;
         bit          pop;
         bit          wr;
         logic [1:0]  sel;
         frame_t      f;
         m_cycle++;
         pre = mq.size();
         pop = (pre != 0) && (!ser_busy || ser_end == m_cycle);
         if (ser_busy && ser_end == m_cycle && !pop) ser_busy = 1'b0;
         if (pop) begin
            f.b = mq.pop_front();
            f.d = (m_baud == 16'd0) ? 1 : int'(m_baud);
            exp_q.push_back(f);
            ser_busy = 1'b1;
            ser_end  = m_cycle + 10 * f.d;
         end
         wr  = bus_if.enable && (bus_if.state == BUS_WRITE) && (bus_if.address[31:4] == BASE[31:4]);
         sel = bus_if.address[3:2];
         if (wr && sel == 2'd0 && bus_if.frame_mask[3]) begin
            if (pre < DEPTH || pop) mq.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
         end
         if (wr && sel == 2'd1 && bus_if.frame_mask[3] && wdata[3]) m_ovf = 1'b0;
         if (wr && sel == 2'd2) begin
            if (bus_if.frame_mask[3]) m_baud[7:0]  = wdata[7:0];
            if (bus_if.frame_mask[2]) m_baud[15:8] = wdata[15:8];
         end
      end
   end

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s       = '0;
      s[0]    = ser_busy || (mq.size() != 0);
      s[1]    = (mq.size() == DEPTH);
      s[2]    = (mq.size() == 0);
      s[3]    = m_ovf;
      s[12:8] = 5'(mq.size());
      return s;
   endfunction

   task automatic bus_idle();
      bus_if.enable     = 1'b0;
      bus_if.state      = BUS_READ;
      bus_if.address    = '0;
      bus_if.frame_mask = '0;
      drive_en          = 1'b0;
      wdata             = '0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      bus_if.enable     = 1'b1;
      bus_if.state      = BUS_WRITE;
      bus_if.address    = addr;
      bus_if.frame_mask = mask;
      wdata             = data;
      drive_en          = 1'b1;
      @(negedge clk);
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] addr, input string name);
      logic [31:0] e;
      case (addr[3:2])
         2'd0:    e = '0;
         2'd1:    e = exp_status();
         2'd2:    e = {16'h0000, m_baud};
         default: e = '1;
      endcase
      if (addr[31:4] != BASE[31:4]) e = '1;
      rd_exp_q.push_back(e);
      rd_name_q.push_back(name);
      bus_if.enable     = 1'b1;
      bus_if.state      = BUS_READ;
      bus_if.address    = addr;
      bus_if.frame_mask = 4'hF;
      drive_en          = 1'b0;
      rd_active         = 1'b1;
      @(negedge clk);
      rd_active = 1'b0;
      bus_idle();
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned k;
      k = 0;
      while ((ser_busy || mq.size() != 0) && k < limit) begin
         @(negedge clk);
         k++;
      end
      check("drain_in_time", {31'b0, k < limit}, 32'd1);
      repeat (3) @(negedge clk);
      check("frames_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Read monitor: compares the bus mid-cycle whenever a read is presented.
   initial begin : rd_mon
      logic [31:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         #2;
         if (rd_active) begin
            if (rd_exp_q.size() == 0) begin
               check("read_without_expectation", bus_data, 32'hDEAD_BEEF);
            end else begin
               e  = rd_exp_q.pop_front();
               nm = rd_name_q.pop_front();
               check(nm, bus_data, e);
            end
         end
      end
   end

   initial begin : busy_mon
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) check("tx_busy", {31'b0, tx_busy}, {31'b0, ser_busy || (mq.size() != 0)});
      end
   end

   // UART monitor: every low on an idle line must be the start of the next expected frame.
   initial begin : uart_mon
      frame_t      f;
      bit          ok;
      bit          aborted;
      int unsigned bad_at;
      logic        bad_got;
      logic        bad_exp;
      logic        e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && uart_tx == 1'b0) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame: uart_tx got 0 at cycle %0d, expected idle 1", m_cycle);
               for (int k = 0; k < 400 && uart_tx == 1'b0; k++) @(negedge clk);
            end else begin
               f = exp_q.pop_front();
               start_q.push_back(m_cycle);
               ok = 1'b1; aborted = 1'b0; bad_at = 0; bad_got = 1'b0; bad_exp = 1'b0;
               for (int unsigned i = 0; i < 10 * f.d; i++) begin
                  if (i != 0) begin
                     @(negedge clk);
                     #1;
                  end
                  if (!rst_n) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (i < f.d) e = 1'b0;
                  else if (i >= 9 * f.d) e = 1'b1;
                  else e = f.b[3'(i / f.d - 1)];
                  if (ok && uart_tx !== e) begin
                     ok = 1'b0; bad_at = i; bad_got = uart_tx; bad_exp = e;
                  end
               end
               if (!aborted) begin
                  n_cmp++;
                  if (!ok) begin
                     n_bad++;
                     $display("FAIL frame_%02h: sample %0d of %0d (divisor %0d) got %b, expected %b",
                              f.b, bad_at, 10 * f.d, f.d, bad_got, bad_exp);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int unsigned op;
      bus_idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("reset_tx_busy", {31'b0, tx_busy}, 32'd0);
      check("reset_bus_released", bus_data, 32'hFFFF_FFFF);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(BASE + 32'h4, "status_after_reset");
      bus_read(BASE + 32'h8, "baud_after_reset");

      // single 0x41 frame at divisor 4
      bus_write(BASE + 32'h8, 32'd4, 4'b1100);
      bus_write(BASE, 32'h41, 4'b1000);
      drain(200);

      // back-to-back frames at divisor 1
      bus_write(BASE + 32'h8, 32'd1, 4'b1100);
      start_q.delete();
      bus_write(BASE, 32'h55, 4'b1000);
      bus_write(BASE, 32'hAA, 4'b1000);
      bus_read(BASE + 32'h4, "status_back_to_back");
      drain(100);
      if (start_q.size() == 2) check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd10);
      else check("b2b_frame_count", 32'(start_q.size()), 32'd2);

      // overflow at divisor 16
      bus_write(BASE + 32'h8, 32'd16, 4'b1100);
      for (int i = 0; i < 20; i++) bus_write(BASE, 32'($urandom_range(0, 255)), 4'b1000);
      bus_read(BASE + 32'h4, "status_overflow");
      bus_write(BASE + 32'h4, 32'h8, 4'b1000);
      bus_read(BASE + 32'h4, "status_overflow_cleared");
      drain(4000);

      // ignored accesses and zero divisor
      bus_write(BASE, 32'h5A, 4'b0111);
      bus_write(BASE + 32'hC, 32'h0000_0077, 4'b1111);
      bus_write(BASE + 32'h10, 32'h66, 4'b1000);
      bus_read(BASE + 32'h4, "status_after_ignored");
      bus_read(BASE + 32'hC, "unmapped_read");
      bus_read(BASE + 32'h10, "outside_window_read");
      bus_read(BASE + 32'h1, "txdata_read");
      bus_write(BASE + 32'h8, 32'd0, 4'b1100);
      bus_read(BASE + 32'h8, "baud_zero");
      bus_write(BASE, 32'hC3, 4'b1000);
      drain(100);

      // push into a full FIFO on the edge a frame ends
      bus_write(BASE + 32'h8, 32'd2, 4'b1100);
      for (int i = 0; i < 17; i++) bus_write(BASE, 32'(8'h80 + i), 4'b1000);
      op = 0;
      while (!(ser_busy && mq.size() == DEPTH && ser_end == m_cycle + 1) && op < 200) begin
         @(negedge clk);
         op++;
      end
      check("full_pop_alignment", {31'b0, op < 200}, 32'd1);
      bus_write(BASE, 32'h31, 4'b1000);
      bus_read(BASE + 32'h4, "status_full_push_pop");
      drain(1000);

      // reset in the middle of a frame
      bus_write(BASE + 32'h8, 32'd8, 4'b1100);
      bus_write(BASE, 32'hF0, 4'b1000);
      bus_write(BASE, 32'h11, 4'b1000);
      bus_write(BASE, 32'h22, 4'b1000);
      bus_write(BASE, 32'h33, 4'b1000);
      repeat (25) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_frame_tx_high", {31'b0, uart_tx}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(BASE + 32'h4, "status_after_mid_reset");
      bus_read(BASE + 32'h8, "baud_after_mid_reset");
      repeat (200) @(negedge clk);

      // randomized traffic
      for (int i = 0; i < 120; i++) begin
         op = $urandom_range(0, 9);
         if (op <= 4) begin
            bus_write(BASE + {28'h0, 2'd0, 2'($urandom_range(0, 3))}, 32'($urandom()),
                      ($urandom_range(0, 4) != 0) ? 4'b1000 : 4'(($urandom_range(0, 7))));
         end else if (op == 5) begin
            bus_read(BASE + 32'h4, "rand_status");
         end else if (op == 6) begin
            bus_write(BASE + 32'h8, 32'($urandom_range(0, 3)), 4'b1100);
         end else if (op == 7) begin
            bus_read(BASE + 32'h8, "rand_baud");
         end else if (op == 8) begin
            bus_write(BASE + 32'h4, 32'($urandom_range(0, 15)), 4'b1000);
         end else begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
         end
      end
      drain(8000);
      check("reads_pending", 32'(rd_exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
